// File: rtl/mic_capture_pkg.sv
// mic_capture_pkg: shared types and constants for the mic capture path.
// Capture states, PCM width, default settle delay, saturating magnitude.
package mic_capture_pkg;

  localparam int PCM_W          = 16;
  localparam int DEF_SAMPLE_DLY = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // -32768 has no positive twin, so it saturates to 32767
  function automatic logic [PCM_W-1:0] sat_abs(
    input logic [PCM_W-1:0] s
  );
    if (s == {1'b1, {(PCM_W-1){1'b0}}})
      return {1'b0, {(PCM_W-1){1'b1}}};
    else if (s[PCM_W-1])
      return -s;
    else
      return s;
  endfunction

endpackage

// File: rtl/fs_strobe_sync.sv
// fs_strobe_sync: syncs fs_i, detects its rising edge and waits a settle
// delay before firing a one-cycle sample event; flags overlapping edges.
module fs_strobe_sync
  import mic_capture_pkg::*;
#(
  parameter int SAMPLE_DLY = DEF_SAMPLE_DLY
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fs_i,
  output logic evt_o,
  output logic ovr_o
);

  localparam int CW = $clog2(SAMPLE_DLY + 1);

  logic [1:0]    sync_q;
  logic          fs_d_q;
  logic          pend_q;
  logic [CW-1:0] cnt_q;
  logic          rise;

  assign rise  = sync_q[1] & ~fs_d_q;
  // a fresh edge restarts the wait, so it masks the expiring one
  assign evt_o = pend_q & (cnt_q == '0) & ~rise;
  assign ovr_o = pend_q & rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      fs_d_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], fs_i};
      fs_d_q <= sync_q[1];
      if (rise) begin
        pend_q <= 1'b1;
        cnt_q  <= CW'(SAMPLE_DLY);
      end else if (evt_o) begin
        pend_q <= 1'b0;
      end else if (pend_q) begin
        cnt_q  <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: start/stop/length-bounded capture of PCM into RAM.
// Define MIC_TRIG_EN for thresh_i and the magnitude trigger in ARMED.
module mic_capture_ctrl
  import mic_capture_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int SAMPLE_DLY = DEF_SAMPLE_DLY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [ADDR_W:0]   len_i,
`ifdef MIC_TRIG_EN
  input  logic [PCM_W-1:0]  thresh_i,
`endif
  input  logic              fs_i,
  input  logic [PCM_W-1:0]  data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PCM_W-1:0]  mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovr_o
);

  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};

  cap_state_e        state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W:0]   len_eff;
  logic              ovr_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PCM_W-1:0]  wdata_q;
  logic              evt;
  logic              ovr_evt;

  fs_strobe_sync #(
    .SAMPLE_DLY(SAMPLE_DLY)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .fs_i  (fs_i),
    .evt_o (evt),
    .ovr_o (ovr_evt)
  );

  // count trails the write strobe by a cycle; fold it in early
  assign cnt_nxt = count_q + {{ADDR_W{1'b0}}, we_q};
  // oversized lengths clamp to the buffer so nothing is overwritten
  assign len_eff = (len_i == '0 || len_i > DEPTH) ?
                   DEPTH : len_i;

`ifdef MIC_TRIG_EN
  logic trig_hit;
  assign trig_hit = sat_abs(data_i) >= thresh_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= 1'b0;
      count_q <= cnt_nxt;
      if (ovr_evt)
        ovr_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ST_ARMED;
            len_q   <= len_eff;
            count_q <= '0;
            ovr_q   <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (stop_i) begin
            state_q <= ST_DONE;
          end else begin
`ifdef MIC_TRIG_EN
            if (evt && trig_hit) begin
              state_q <= ST_CAPTURE;
              we_q    <= 1'b1;
              addr_q  <= cnt_nxt[ADDR_W-1:0];
              wdata_q <= data_i;
            end
`else
            state_q <= ST_CAPTURE;
`endif
          end
        end
        ST_CAPTURE: begin
          if (stop_i) begin
            state_q <= ST_DONE;
          end else if (cnt_nxt == len_q) begin
            state_q <= ST_DONE;
          end else if (evt) begin
            we_q    <= 1'b1;
            addr_q  <= cnt_nxt[ADDR_W-1:0];
            wdata_q <= data_i;
          end
        end
        ST_DONE: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
          end else if (start_i) begin
            state_q <= ST_ARMED;
            len_q   <= len_eff;
            count_q <= '0;
            ovr_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q == ST_ARMED) ||
                       (state_q == ST_CAPTURE);
  assign done_o      = (state_q == ST_DONE);
  assign count_o     = count_q;
  assign ovr_o       = ovr_q;

endmodule

// File: doc/mic_capture_ctrl.md
# mic_capture_ctrl

Sequences the PDM microphone decimation chain into a sample buffer. Detects each new-sample strobe from the filter chain, waits a fixed settle delay, and writes the 16-bit PCM word into a single-port RAM at an auto-incrementing address. Runs a start/stop/length-bounded capture state machine. Sits between the PDM filter output (clk_i domain) and the audio buffer RAM, and is commanded by the processor's register interface.

## Interface
- ADDR_W, 14: buffer address width; depth is 2^ADDR_W words.
- SAMPLE_DLY, 64: clk_i cycles from the detected fs rising edge to sampling data_i (must exceed one 3.072 MHz period plus margin).
- clk_i  in  1  system clock (100 MHz); one clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse that begins a capture; ignored unless the state is IDLE or DONE.
- stop_i  in  1  one-cycle pulse that aborts a capture in any non-IDLE state.
- len_i  in  ADDR_W+1  number of samples to capture; latched on start; 0 means 2^ADDR_W.
- thresh_i  in  16  trigger magnitude; present only with MIC_TRIG_EN.
- fs_i  in  1  sample-valid level from the filter chain; may stay high for several clk_i cycles.
- data_i  in  16  signed PCM sample from the filter chain.
- mem_we_o  out  1  RAM write strobe, one cycle per sample.
- mem_addr_o  out  ADDR_W  RAM write address.
- mem_wdata_o  out  16  RAM write data.
- busy_o  out  1  high in ARMED and CAPTURE.
- done_o  out  1  high in DONE; cleared by start_i or stop_i.
- count_o  out  ADDR_W+1  samples written in the current or last capture.
- ovr_o  out  1  sticky flag: a new fs edge arrived while a sample was still pending; cleared on start.

## Operation
- fs_i passes through a 2-flop synchronizer. A rising edge of the synchronized signal raises a pending flag and loads the delay counter with SAMPLE_DLY.
- When the counter reaches 0, data_i is latched and a sample event fires. If a second edge arrives while the flag is pending: set ovr_o, reload the counter, and emit only one event.
- States:
  - IDLE: start_i goes to ARMED; latch len_i; clear count_o and ovr_o.
  - ARMED: with MIC_TRIG_EN, go to CAPTURE on the first event with |sample| >= thresh_i. That sample is written. Without the macro, ARMED lasts one cycle.
  - CAPTURE: each event writes a word. When count_o reaches the latched length, go to DONE.
  - DONE: start_i begins a new capture (goes to ARMED).
- Write address = count_o[ADDR_W-1:0] at the time of the write, then count_o increments. The address wraps naturally only when length is 2^ADDR_W (it ends on the last address).
- stop_i in ARMED or CAPTURE goes to DONE, keeping count_o. stop_i in DONE goes to IDLE. stop_i wins over a same-cycle sample event (no write).
- start_i in ARMED or CAPTURE is ignored. start_i together with stop_i: stop wins.
- Magnitude: |-32768| is taken as 32767 (saturating absolute value).

## Timing
- Reset values: all outputs 0. State is IDLE. The synchronizer, pending flag and counter are cleared.
- Edge-to-write latency: 2 sync cycles + 1 edge-detect cycle + SAMPLE_DLY + 1 register cycle.
- mem_we_o, mem_addr_o and mem_wdata_o are registered and valid together for exactly one cycle.
- count_o updates the cycle after mem_we_o. The DONE transition and done_o occur on that same cycle.
- Reset asserted mid-capture aborts without a write on the following cycle.

## Configuration
- MIC_TRIG_EN:
  - Defined: the thresh_i port and the level-triggered ARMED wait are compiled in.
  - Undefined: no thresh_i port, and ARMED passes straight to CAPTURE after one cycle.

## Structure
- Package mic_capture_pkg:
  - capture state enum (IDLE, ARMED, CAPTURE, DONE)
  - default SAMPLE_DLY
  - PCM width constant (16)
- Sub-module fs_strobe_sync contains the synchronizer, edge detect, delay counter and pending/overrun logic. It outputs a sample event pulse and an overrun pulse.

## Test plan
- Reset, then start_i with len_i=4 and four fs pulses of data 0x0001..0x0004 -> writes at addresses 0..3 with matching data; done_o=1; count_o=4.
- fs_i held high for 10 cycles -> exactly one write.
- A second fs edge 20 cycles after the first, with SAMPLE_DLY=64 -> ovr_o=1 and one write.
- stop_i after 2 of 8 samples -> DONE with count_o=2; no further writes on later fs pulses.
- len_i=0 with ADDR_W=4 -> 16 writes at addresses 0..15, then DONE.
- MIC_TRIG_EN, thresh_i=0x1000, samples 0x0100, 0xF000, 0x0200 -> first write is 0xF000 (|-4096| meets the threshold), then 0x0200.
